// File: rtl/hdlc_rx_protocol_checker.sv
// Purpose: on-the-fly Rx protocol checker (flag-detect latency, abort-signal window, DataOut idle stability).
// Latency: an error evaluated in cycle c pulses ErrPulse in cycle c+1; counters and sticky flags update at that same edge.
// Backpressure: none; a passive monitor that never stalls the Rx datapath it observes.
module hdlc_rx_protocol_checker #(
   parameter int FLAG_LAT  = 2,
   parameter int ABORT_LAT = 1,
   parameter int IDLE_LEN  = 8,
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Enable,
   input  logic              Clear,
   input  logic              Rx,
   input  logic              Rx_FlagDetect,
   input  logic              Rx_ValidFrame,
   input  logic              Rx_AbortDetect,
   input  logic              Rx_AbortSignal,
   input  logic [DATA_W-1:0] DataOut,
   output logic [2:0]        ErrPulse,
   output logic [2:0]        ErrFlag,
   output logic [CNT_W-1:0]  FlagCnt,
   output logic [CNT_W-1:0]  FlagErrCnt,
   output logic [CNT_W-1:0]  AbortErrCnt,
   output logic [CNT_W-1:0]  IdleErrCnt,
   output logic [CNT_W-1:0]  ErrCnt
);

   localparam int RUN_W = $clog2(IDLE_LEN + 1);
   localparam int TMR_W = $clog2(ABORT_LAT + 1);
   localparam logic [7:0]       FLAG_PAT = 8'b0111_1110;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {AbortIdle, AbortWait} abortState_t;

   // Only the 7 previous samples are stored; the current Rx completes the 8-sample window.
   logic [6:0]          rxHist;
   logic [7:0]          rxWin;
   logic                flagMatch;
   logic [FLAG_LAT-1:0] flagPend;
   abortState_t         abortState;
   logic [TMR_W-1:0]    abortTmr;
   logic                abortTrig;
   logic                abortDone;
   logic [RUN_W-1:0]    runCnt;
   logic [RUN_W-1:0]    runNext;
   logic [DATA_W-1:0]   dataPrev;
   logic                flagErr;
   logic                abortErr;
   logic                idleErr;
   logic [2:0]          errNow;
   logic [1:0]          errSum;

   function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
      logic [CNT_W+1:0] sum;
      sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
      return (sum > {2'b00, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
   endfunction

   // Per-cycle evaluation of the three checks; matches and errors are suppressed while disabled.
   always_comb begin
      rxWin     = {rxHist, Rx};
      flagMatch = Enable && !Clear && (rxWin == FLAG_PAT);
      flagErr   = Enable && flagPend[FLAG_LAT-1] && !Rx_FlagDetect;

      abortTrig = Enable && Rx_AbortDetect && Rx_ValidFrame;
      abortDone = (abortState == AbortWait) && (Rx_AbortSignal || (abortTmr == TMR_W'(1)));
      abortErr  = Enable && (abortState == AbortWait) && !Rx_AbortSignal && (abortTmr == TMR_W'(1));

      if (!Rx)
         runNext = '0;
      else if (runCnt >= RUN_W'(IDLE_LEN))
         runNext = RUN_W'(IDLE_LEN);
      else
         runNext = runCnt + 1'b1;
      idleErr = Enable && (runNext == RUN_W'(IDLE_LEN)) && (DataOut != dataPrev);

      errNow = {idleErr, abortErr, flagErr};
      errSum = {1'b0, flagErr} + {1'b0, abortErr} + {1'b0, idleErr};
   end

   // Rx sample history and DataOut history run every cycle, independent of Enable.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rxHist   <= '0;
         dataPrev <= '0;
      end else begin
         rxHist   <= rxWin[6:0];
         dataPrev <= DataOut;
      end
   end

   // Pending-flag pipeline: a match at t reaches the last stage in cycle t+FLAG_LAT.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         flagPend <= '0;
      end else if (!Enable) begin
         flagPend <= '0;
      end else begin
         flagPend[0] <= flagMatch;
         for (int i = 1; i < FLAG_LAT; i++)
            flagPend[i] <= flagPend[i-1];
      end
   end

   // Abort window FSM; retriggering is only possible once the current window has closed.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         abortState <= AbortIdle;
         abortTmr   <= '0;
      end else if (!Enable) begin
         abortState <= AbortIdle;
         abortTmr   <= '0;
      end else begin
         case (abortState)
            AbortIdle: begin
               if (abortTrig) begin
                  abortState <= AbortWait;
                  abortTmr   <= TMR_W'(ABORT_LAT);
               end
            end
            AbortWait: begin
               if (abortDone && abortTrig) begin
                  abortState <= AbortWait;
                  abortTmr   <= TMR_W'(ABORT_LAT);
               end else if (abortDone) begin
                  abortState <= AbortIdle;
                  abortTmr   <= '0;
               end else begin
                  abortTmr   <= abortTmr - 1'b1;
               end
            end
            default: begin
               abortState <= AbortIdle;
               abortTmr   <= '0;
            end
         endcase
      end
   end

   // Run length of consecutive Rx=1 samples, saturating at IDLE_LEN.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         runCnt <= '0;
      else if (!Enable)
         runCnt <= '0;
      else
         runCnt <= runNext;
   end

   // Registered outputs; Clear wins over anything evaluated in the same cycle.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst || Clear) begin
         ErrPulse    <= '0;
         ErrFlag     <= '0;
         FlagCnt     <= '0;
         FlagErrCnt  <= '0;
         AbortErrCnt <= '0;
         IdleErrCnt  <= '0;
         ErrCnt      <= '0;
      end else begin
         ErrPulse    <= errNow;
         ErrFlag     <= ErrFlag | errNow;
         FlagCnt     <= satAdd(FlagCnt, {1'b0, flagMatch});
         FlagErrCnt  <= satAdd(FlagErrCnt, {1'b0, flagErr});
         AbortErrCnt <= satAdd(AbortErrCnt, {1'b0, abortErr});
         IdleErrCnt  <= satAdd(IdleErrCnt, {1'b0, idleErr});
         ErrCnt      <= satAdd(ErrCnt, errSum);
      end
   end

endmodule

// File: doc/hdlc_rx_protocol_checker.md
Name: hdlc_rx_protocol_checker

Overview:
Synthesizable, parametrised Rx-side protocol checker for the HDLC block. It monitors the Rx serial line and the Rx status/data outputs and performs three checks on the fly:
- flag-detect latency,
- abort-signal response window,
- DataOut stability during idle.

It reports per-check one-cycle error pulses, sticky error flags and saturating counters. It sits beside the Rx datapath and is readable from the testbench or a status register, so the checking also works in emulation and gate-level runs.

Parameters:
FLAG_LAT, 2, cycles from flag match to required Rx_FlagDetect (>=1)
ABORT_LAT, 1, window length in cycles for Rx_AbortSignal after an abort trigger (>=1)
IDLE_LEN, 8, consecutive Rx=1 samples that constitute idle (>=2)
DATA_W, 32, DataOut width
CNT_W, 16, width of all counters

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  reset; asynchronous, active-high
Enable  in  1  checking active when 1
Clear  in  1  synchronous clear of counters, sticky flags and pulses
Rx  in  1  serial receive line
Rx_FlagDetect  in  1  DUT flag-detect strobe
Rx_ValidFrame  in  1  DUT valid-frame status
Rx_AbortDetect  in  1  DUT abort-detect strobe
Rx_AbortSignal  in  1  DUT abort-signal output
DataOut  in  DATA_W  DUT read-data bus
ErrPulse  out  3  one-cycle error strobe; [0]=flag, [1]=abort, [2]=idle
ErrFlag  out  3  sticky error flags, same bit mapping
FlagCnt  out  CNT_W  flags matched
FlagErrCnt  out  CNT_W  flag-latency errors
AbortErrCnt  out  CNT_W  abort-window errors
IdleErrCnt  out  CNT_W  idle-stability errors
ErrCnt  out  CNT_W  total errors

Behaviour:
- Reset: all outputs 0. Shift register, pending pipeline, run counter and DataOut history are 0. Abort FSM is in IDLE. Reset mid-operation discards every outstanding expectation; no error is raised for it.
- Outputs are registered. An error evaluated in cycle c gives ErrPulse high during cycle c+1 only; counters and ErrFlag update at that same edge.
- Flag check:
  - Rx is sampled into an 8-bit history.
  - A flag matches in cycle t when the last 8 samples, oldest first, are 0111_1110 (the trailing 0 is sampled at t).
  - Overlapping flags sharing a 0 each match.
  - Each match increments FlagCnt and loads a FLAG_LAT-deep pending pipeline.
  - At t+FLAG_LAT, Rx_FlagDetect must be 1; otherwise a flag error is raised.
  - An extra Rx_FlagDetect with no pending match is not an error.
- Abort check, FSM with states IDLE and WAIT:
  - In IDLE, Rx_AbortDetect && Rx_ValidFrame at cycle t moves the FSM to WAIT with timer=ABORT_LAT.
  - The window is cycles t+1..t+ABORT_LAT. Rx_AbortSignal seen in the window returns to IDLE with no error.
  - If the timer expires without Rx_AbortSignal, an abort error is raised and the FSM returns to IDLE.
  - A new trigger during WAIT is ignored (the window is not extended).
  - Rx_AbortSignal in cycle t itself does not satisfy the check.
  - A trigger can be accepted in the same cycle the FSM returns to IDLE.
  - ABORT_LAT=1 means Rx_AbortSignal is required exactly at t+1.
- Idle check:
  - The run counter counts consecutive Rx=1 samples, saturating at IDLE_LEN; Rx=0 clears it.
  - In every cycle where the counter (including the current sample) is >= IDLE_LEN, DataOut must equal DataOut of the previous cycle; otherwise an idle error is raised.
  - DataOut history is registered every cycle, regardless of Enable.
- Enable=0: no checks and no matches. Pending pipeline, FSM and run counter are flushed. Counters and flags hold.
- Counters:
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - ErrCnt adds the number of errors raised in the cycle (0..3), saturating.
  - Simultaneous errors set all corresponding ErrPulse/ErrFlag bits.
- Clear: zeroes counters, ErrFlag and ErrPulse. It has priority: errors and matches evaluated in the same cycle are dropped. Expectations in flight are retained.

Test Plan:
1. Defaults. Drive Rx 0,1,1,1,1,1,1,0 (trailing 0 at t), Rx_FlagDetect=1 at t+2 -> ErrPulse=0, FlagCnt=1, FlagErrCnt=0.
2. Same flag with Rx_FlagDetect held 0 -> ErrPulse[0]=1 in cycle t+3 only, ErrFlag[0]=1 sticky, FlagErrCnt=1, ErrCnt=1.
3. ABORT_LAT=3, trigger at t:
   - Rx_AbortSignal at t+3 -> no error.
   - Repeat with Rx_AbortSignal at t+4 -> AbortErrCnt=1.
   - Trigger with Rx_ValidFrame=0 -> no check started.
4. Rx=1 for 10 cycles, DataOut constant except a change at cycle 9 -> IdleErrCnt=1. A change at cycle 5 -> no error.
5. CNT_W=2: five missing-FlagDetect flags -> FlagErrCnt=3, ErrCnt=3. Then Clear=1 one cycle -> all counters and ErrFlag=0.
6. Flag matched and abort trigger in the same cycle, then Rst (or Enable=0) at t+1 -> no ErrPulse afterwards, all outputs 0 (reset) or held (Enable).
